// File: rtl/vcve2_wb_stage.sv
// Writeback stage for the vector CVE2 core: holds one retiring instruction, waits for
// scalar load responses, and assembles multi-beat vector loads into one VLEN-wide write.
module vcve2_wb_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned VLEN = 128
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_id_i,
    output logic            ready_wb_o,
    input  logic            instr_is_compressed_id_i,
    input  logic            instr_perf_count_id_i,
    input  logic [4:0]      rf_waddr_id_i,
    input  logic [XLEN-1:0] rf_wdata_id_i,
    input  logic            rf_we_id_i,
    input  logic            rf_load_id_i,
    input  logic [4:0]      vrf_waddr_id_i,
    input  logic [VLEN-1:0] vrf_wdata_id_i,
    input  logic            vrf_we_id_i,
    input  logic            vrf_load_id_i,
    input  logic            lsu_resp_valid_i,
    input  logic            lsu_resp_err_i,
    input  logic [XLEN-1:0] lsu_rdata_i,
    output logic [4:0]      rf_waddr_wb_o,
    output logic [XLEN-1:0] rf_wdata_wb_o,
    output logic            rf_we_wb_o,
    output logic [4:0]      vrf_waddr_wb_o,
    output logic [VLEN-1:0] vrf_wdata_wb_o,
    output logic            vrf_we_wb_o,
    output logic            rf_wpend_o,
    output logic            vrf_wpend_o,
    output logic            perf_instr_ret_wb_o,
    output logic            perf_instr_ret_compressed_wb_o
);

    localparam int unsigned VBEATS = VLEN / XLEN;
    localparam int unsigned CNT_W  = (VBEATS > 1) ? $clog2(VBEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VBEATS - 1);

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_FULL     = 2'd1,
        S_WAIT_LD  = 2'd2,
        S_WAIT_VLD = 2'd3
    } state_e;

    state_e            r_state;
    logic [4:0]        r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic              r_rf_we;
    logic [4:0]        r_vrf_waddr;
    logic [VLEN-1:0]   r_vrf_wdata;
    logic              r_vrf_we;
    logic              r_compressed;
    logic              r_perf;
    logic [CNT_W-1:0]  r_cnt;
    logic [VLEN-1:0]   r_vbuf;

    logic              w_beat_ok;
    logic              w_vld_last;
    logic              w_retire;
    logic [VLEN-1:0]   w_vbuf_merged;

    assign w_beat_ok  = lsu_resp_valid_i & ~lsu_resp_err_i;
    assign w_vld_last = (r_cnt == CNT_LAST);
    assign ready_wb_o = (r_state == S_EMPTY) | (r_state == S_FULL);

    // Current beat overlaid on the partially assembled vector at the slot picked by r_cnt.
    always_comb begin
        w_vbuf_merged = r_vbuf;
        for (int b = 0; b < int'(VBEATS); b++) begin
            if (r_cnt == CNT_W'(b)) begin
                w_vbuf_merged[b*XLEN +: XLEN] = lsu_rdata_i;
            end else begin
                w_vbuf_merged[b*XLEN +: XLEN] = r_vbuf[b*XLEN +: XLEN];
            end
        end
    end

    // Stage FSM: entry capture, load waiting and vector beat assembly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_EMPTY;
            r_rf_waddr   <= 5'd0;
            r_rf_wdata   <= '0;
            r_rf_we      <= 1'b0;
            r_vrf_waddr  <= 5'd0;
            r_vrf_wdata  <= '0;
            r_vrf_we     <= 1'b0;
            r_compressed <= 1'b0;
            r_perf       <= 1'b0;
            r_cnt        <= '0;
            r_vbuf       <= '0;
        end else begin
            case (r_state)
                S_EMPTY, S_FULL: begin
                    if (valid_id_i) begin
                        r_rf_waddr   <= rf_waddr_id_i;
                        r_rf_wdata   <= rf_wdata_id_i;
                        r_rf_we      <= rf_we_id_i;
                        r_vrf_waddr  <= vrf_waddr_id_i;
                        r_vrf_wdata  <= vrf_wdata_id_i;
                        r_vrf_we     <= vrf_we_id_i;
                        r_compressed <= instr_is_compressed_id_i;
                        r_perf       <= instr_perf_count_id_i;
                        r_cnt        <= '0;
                        if (vrf_load_id_i) begin
                            r_state <= S_WAIT_VLD;
                        end else if (rf_load_id_i) begin
                            r_state <= S_WAIT_LD;
                        end else begin
                            r_state <= S_FULL;
                        end
                    end else begin
                        r_state <= S_EMPTY;
                    end
                end
                S_WAIT_LD: begin
                    if (lsu_resp_valid_i) begin
                        r_state <= S_EMPTY;
                    end else begin
                        r_state <= S_WAIT_LD;
                    end
                end
                S_WAIT_VLD: begin
                    // An errored beat aborts the whole vector; the LSU sends nothing more for it.
                    if (lsu_resp_valid_i && (lsu_resp_err_i || w_vld_last)) begin
                        r_state <= S_EMPTY;
                        r_cnt   <= '0;
                    end else if (lsu_resp_valid_i) begin
                        r_vbuf  <= w_vbuf_merged;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state <= S_WAIT_VLD;
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Write ports and retire pulse; load completions forward LSU data in the response cycle.
    always_comb begin
        rf_we_wb_o     = 1'b0;
        rf_wdata_wb_o  = '0;
        vrf_we_wb_o    = 1'b0;
        vrf_wdata_wb_o = '0;
        w_retire       = 1'b0;
        case (r_state)
            S_FULL: begin
                rf_we_wb_o     = r_rf_we;
                rf_wdata_wb_o  = r_rf_we ? r_rf_wdata : '0;
                vrf_we_wb_o    = r_vrf_we;
                vrf_wdata_wb_o = r_vrf_we ? r_vrf_wdata : '0;
                w_retire       = r_perf;
            end
            S_WAIT_LD: begin
                if (w_beat_ok) begin
                    rf_we_wb_o    = 1'b1;
                    rf_wdata_wb_o = lsu_rdata_i;
                    w_retire      = r_perf;
                end else begin
                    rf_we_wb_o    = 1'b0;
                end
            end
            S_WAIT_VLD: begin
                if (w_beat_ok && w_vld_last) begin
                    vrf_we_wb_o    = 1'b1;
                    vrf_wdata_wb_o = w_vbuf_merged;
                    w_retire       = r_perf;
                end else begin
                    vrf_we_wb_o    = 1'b0;
                end
            end
            default: begin
                w_retire = 1'b0;
            end
        endcase
    end

    assign rf_waddr_wb_o                  = r_rf_waddr;
    assign vrf_waddr_wb_o                 = r_vrf_waddr;
    assign perf_instr_ret_wb_o            = w_retire;
    assign perf_instr_ret_compressed_wb_o = w_retire & r_compressed;
    assign rf_wpend_o  = r_rf_we  & ((r_state == S_FULL) | (r_state == S_WAIT_LD));
    assign vrf_wpend_o = r_vrf_we & ((r_state == S_FULL) | (r_state == S_WAIT_VLD));

endmodule

// File: tb/tb_vcve2_wb_stage.sv
// Directed bench for vcve2_wb_stage: a transaction-level model checks the VLEN=128 instance
// every cycle, literal checks pin key results, and a VLEN=XLEN instance covers single-beat loads.
module tb_vcve2_wb_stage;

    localparam int XLEN = 32;
    localparam int VLEN = 128;
    localparam int VB   = VLEN / XLEN;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic valid_id_i, instr_is_compressed_id_i, instr_perf_count_id_i;
    logic [4:0] rf_waddr_id_i, vrf_waddr_id_i;
    logic [31:0] rf_wdata_id_i;
    logic [127:0] vrf_wdata_id_i;
    logic rf_we_id_i, rf_load_id_i, vrf_we_id_i, vrf_load_id_i;
    logic lsu_resp_valid_i, lsu_resp_err_i;
    logic [31:0] lsu_rdata_i;

    logic ready_wb_o, rf_we_wb_o, vrf_we_wb_o, rf_wpend_o, vrf_wpend_o;
    logic perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o;
    logic [4:0] rf_waddr_wb_o, vrf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o;
    logic [127:0] vrf_wdata_wb_o;

    logic d2_ready, d2_rf_we, d2_vrf_we, d2_rf_wpend, d2_vrf_wpend, d2_ret, d2_retc;
    logic [4:0] d2_rf_waddr, d2_vrf_waddr;
    logic [31:0] d2_rf_wdata;
    logic [31:0] d2_vrf_wdata;

    int checks = 0;
    int errors = 0;

    vcve2_wb_stage #(.XLEN(XLEN), .VLEN(VLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_id_i(valid_id_i), .ready_wb_o(ready_wb_o),
        .instr_is_compressed_id_i(instr_is_compressed_id_i), .instr_perf_count_id_i(instr_perf_count_id_i),
        .rf_waddr_id_i(rf_waddr_id_i), .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i),
        .rf_load_id_i(rf_load_id_i), .vrf_waddr_id_i(vrf_waddr_id_i), .vrf_wdata_id_i(vrf_wdata_id_i),
        .vrf_we_id_i(vrf_we_id_i), .vrf_load_id_i(vrf_load_id_i), .lsu_resp_valid_i(lsu_resp_valid_i),
        .lsu_resp_err_i(lsu_resp_err_i), .lsu_rdata_i(lsu_rdata_i), .rf_waddr_wb_o(rf_waddr_wb_o),
        .rf_wdata_wb_o(rf_wdata_wb_o), .rf_we_wb_o(rf_we_wb_o), .vrf_waddr_wb_o(vrf_waddr_wb_o),
        .vrf_wdata_wb_o(vrf_wdata_wb_o), .vrf_we_wb_o(vrf_we_wb_o), .rf_wpend_o(rf_wpend_o),
        .vrf_wpend_o(vrf_wpend_o), .perf_instr_ret_wb_o(perf_instr_ret_wb_o),
        .perf_instr_ret_compressed_wb_o(perf_instr_ret_compressed_wb_o)
    );

    vcve2_wb_stage #(.XLEN(32), .VLEN(32)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_id_i(valid_id_i), .ready_wb_o(d2_ready),
        .instr_is_compressed_id_i(instr_is_compressed_id_i), .instr_perf_count_id_i(instr_perf_count_id_i),
        .rf_waddr_id_i(rf_waddr_id_i), .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i),
        .rf_load_id_i(rf_load_id_i), .vrf_waddr_id_i(vrf_waddr_id_i), .vrf_wdata_id_i(vrf_wdata_id_i[31:0]),
        .vrf_we_id_i(vrf_we_id_i), .vrf_load_id_i(vrf_load_id_i), .lsu_resp_valid_i(lsu_resp_valid_i),
        .lsu_resp_err_i(lsu_resp_err_i), .lsu_rdata_i(lsu_rdata_i), .rf_waddr_wb_o(d2_rf_waddr),
        .rf_wdata_wb_o(d2_rf_wdata), .rf_we_wb_o(d2_rf_we), .vrf_waddr_wb_o(d2_vrf_waddr),
        .vrf_wdata_wb_o(d2_vrf_wdata), .vrf_we_wb_o(d2_vrf_we), .rf_wpend_o(d2_rf_wpend),
        .vrf_wpend_o(d2_vrf_wpend), .perf_instr_ret_wb_o(d2_ret),
        .perf_instr_ret_compressed_wb_o(d2_retc)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model of the held instruction ----------------
    typedef struct {
        logic [4:0] ra; logic [31:0] rd; logic rwe; logic rld;
        logic [4:0] va; logic [127:0] vd; logic vwe; logic vld;
        logic c; logic p;
    } ins_t;

    ins_t m_ins;
    bit m_held = 1'b0;
    int m_beats = 0;
    logic [127:0] m_vec = '0;
    int kind;
    logic e_ready, e_rwe, e_vwe, e_rpend, e_vpend, e_ret, e_retc;
    logic [31:0] e_rwd;
    logic [127:0] e_vwd, beat_sh;
    bit accepted;

    initial m_ins = '{ra: 5'd0, rd: 32'd0, rwe: 1'b0, rld: 1'b0, va: 5'd0, vd: 128'd0,
                      vwe: 1'b0, vld: 1'b0, c: 1'b0, p: 1'b0};

    always @(negedge clk_i) begin
        e_rwe = 1'b0; e_vwe = 1'b0; e_rpend = 1'b0; e_vpend = 1'b0; e_ret = 1'b0;
        e_rwd = 32'd0; e_vwd = 128'd0; e_ready = 1'b1;
        kind = m_ins.vld ? 2 : (m_ins.rld ? 1 : 0);
        beat_sh = {96'd0, lsu_rdata_i} << (XLEN * m_beats);
        if (rst_i) begin
            m_held = 1'b0; m_beats = 0; m_vec = '0;
            m_ins = '{ra: 5'd0, rd: 32'd0, rwe: 1'b0, rld: 1'b0, va: 5'd0, vd: 128'd0,
                      vwe: 1'b0, vld: 1'b0, c: 1'b0, p: 1'b0};
        end else if (m_held) begin
            e_ready = (kind == 0);
            if (kind == 0) begin
                e_rwe = m_ins.rwe; e_rwd = m_ins.rwe ? m_ins.rd : 32'd0;
                e_vwe = m_ins.vwe; e_vwd = m_ins.vwe ? m_ins.vd : 128'd0;
                e_rpend = m_ins.rwe; e_vpend = m_ins.vwe; e_ret = m_ins.p;
            end else if (kind == 1) begin
                e_rpend = 1'b1;
                if (lsu_resp_valid_i && !lsu_resp_err_i) begin
                    e_rwe = 1'b1; e_rwd = lsu_rdata_i; e_ret = m_ins.p;
                end
            end else begin
                e_vpend = 1'b1;
                if (lsu_resp_valid_i && !lsu_resp_err_i && m_beats == VB - 1) begin
                    e_vwe = 1'b1; e_vwd = m_vec | beat_sh; e_ret = m_ins.p;
                end
            end
        end
        e_retc = e_ret & m_ins.c;

        chk("ready", 128'(ready_wb_o), 128'(e_ready));
        chk("rf_we", 128'(rf_we_wb_o), 128'(e_rwe));
        chk("rf_wdata", 128'(rf_wdata_wb_o), 128'(e_rwd));
        chk("rf_waddr", 128'(rf_waddr_wb_o), 128'(m_ins.ra));
        chk("vrf_we", 128'(vrf_we_wb_o), 128'(e_vwe));
        chk("vrf_wdata", vrf_wdata_wb_o, e_vwd);
        chk("vrf_waddr", 128'(vrf_waddr_wb_o), 128'(m_ins.va));
        chk("rf_wpend", 128'(rf_wpend_o), 128'(e_rpend));
        chk("vrf_wpend", 128'(vrf_wpend_o), 128'(e_vpend));
        chk("retire", 128'(perf_instr_ret_wb_o), 128'(e_ret));
        chk("retire_c", 128'(perf_instr_ret_compressed_wb_o), 128'(e_retc));

        if (!rst_i) begin
            if (valid_id_i && e_ready) begin
                chk("id_rfload_we", 128'(rf_load_id_i & ~rf_we_id_i), 128'(0));
                chk("id_vload_we", 128'(vrf_load_id_i & ~vrf_we_id_i), 128'(0));
                chk("id_both_loads", 128'(rf_load_id_i & vrf_load_id_i), 128'(0));
            end
            if (lsu_resp_valid_i && !(m_held && kind != 0)) begin
                chk("lsu_stray_beat", 128'(lsu_resp_valid_i), 128'(0));
            end
            accepted = valid_id_i && e_ready;
            if (accepted) begin
                m_ins = '{ra: rf_waddr_id_i, rd: rf_wdata_id_i, rwe: rf_we_id_i, rld: rf_load_id_i,
                          va: vrf_waddr_id_i, vd: vrf_wdata_id_i, vwe: vrf_we_id_i,
                          vld: vrf_load_id_i, c: instr_is_compressed_id_i, p: instr_perf_count_id_i};
                m_held = 1'b1; m_beats = 0; m_vec = '0;
            end else if (m_held) begin
                if (kind == 0) begin
                    m_held = 1'b0;
                end else if (kind == 1 && lsu_resp_valid_i) begin
                    m_held = 1'b0;
                end else if (kind == 2 && lsu_resp_valid_i) begin
                    if (lsu_resp_err_i || m_beats == VB - 1) begin
                        m_held = 1'b0;
                    end else begin
                        m_vec = m_vec | beat_sh;
                        m_beats++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic id_set(input logic [4:0] ra, input logic [31:0] rd, input logic rwe, input logic rld,
                          input logic [4:0] va, input logic [127:0] vd, input logic vwe, input logic vld,
                          input logic c, input logic p);
        valid_id_i = 1'b1;
        rf_waddr_id_i = ra; rf_wdata_id_i = rd; rf_we_id_i = rwe; rf_load_id_i = rld;
        vrf_waddr_id_i = va; vrf_wdata_id_i = vd; vrf_we_id_i = vwe; vrf_load_id_i = vld;
        instr_is_compressed_id_i = c; instr_perf_count_id_i = p;
    endtask

    task automatic id_idle();
        id_set(5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        valid_id_i = 1'b0;
    endtask

    task automatic lsu(input logic v, input logic e, input logic [31:0] d);
        lsu_resp_valid_i = v; lsu_resp_err_i = e; lsu_rdata_i = d;
    endtask

    logic [31:0] bd [5];
    logic        bv [5];

    initial begin
        id_idle();
        lsu(1'b0, 1'b0, 32'd0);
        tick(); tick();
        rst_i = 1'b0;

        // ALU op, then three back-to-back ops (one vector non-load)
        tick(); id_set(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); id_idle();
        @(negedge clk_i);
        chk("alu_we", 128'(rf_we_wb_o), 128'(1));
        chk("alu_waddr", 128'(rf_waddr_wb_o), 128'(5));
        chk("alu_wdata", 128'(rf_wdata_wb_o), 128'(32'hDEADBEEF));
        chk("alu_ret", 128'(perf_instr_ret_wb_o), 128'(1));
        tick(); id_set(5'd1, 32'h0000_0A0A, 1'b1, 1'b0, 5'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); id_set(5'd0, 32'd0, 1'b0, 1'b0, 5'd3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                       1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i); chk("b2b_ready1", 128'(ready_wb_o), 128'(1));
        tick(); id_set(5'd2, 32'h0000_0C0C, 1'b1, 1'b0, 5'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("b2b_vwdata", vrf_wdata_wb_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        tick(); id_idle();
        @(negedge clk_i);
        chk("b2b_third", 128'(rf_wdata_wb_o), 128'(32'h0C0C));

        // scalar load to x7, compressed, response after 3 idle cycles
        tick(); id_set(5'd7, 32'd0, 1'b1, 1'b1, 5'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick(); id_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("ld_ready_low", 128'(ready_wb_o), 128'(0));
            chk("ld_wpend", 128'(rf_wpend_o), 128'(1));
            tick();
        end
        lsu(1'b1, 1'b0, 32'h1234_5678);
        @(negedge clk_i);
        chk("ld_wdata", 128'(rf_wdata_wb_o), 128'(32'h12345678));
        chk("ld_retc", 128'(perf_instr_ret_compressed_wb_o), 128'(1));
        chk("ld_ready_resp", 128'(ready_wb_o), 128'(0));
        tick(); lsu(1'b0, 1'b0, 32'd0);
        @(negedge clk_i);
        chk("ld_ready_after", 128'(ready_wb_o), 128'(1));

        // vector load to v2 with a gap
        bd[0] = 32'h1111_1111; bd[1] = 32'h2222_2222; bd[2] = 32'h0; bd[3] = 32'h3333_3333; bd[4] = 32'h4444_4444;
        bv[0] = 1'b1; bv[1] = 1'b1; bv[2] = 1'b0; bv[3] = 1'b1; bv[4] = 1'b1;
        tick(); id_set(5'd0, 32'd0, 1'b0, 1'b0, 5'd2, 128'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); id_idle();
        for (int i = 0; i < 5; i++) begin
            lsu(bv[i], 1'b0, bd[i]);
            @(negedge clk_i);
            if (i < 4) chk("vld_no_early_we", 128'(vrf_we_wb_o), 128'(0));
            else chk("vld_data", vrf_wdata_wb_o, 128'h44444444_33333333_22222222_11111111);
            tick();
        end
        lsu(1'b0, 1'b0, 32'd0);

        // vector load aborted on beat 2, then a clean one
        tick(); id_set(5'd0, 32'd0, 1'b0, 1'b0, 5'd4, 128'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); id_idle();
        lsu(1'b1, 1'b0, 32'h0000_000A); tick();
        lsu(1'b1, 1'b0, 32'h0000_000B); tick();
        lsu(1'b1, 1'b1, 32'h0000_0BAD);
        @(negedge clk_i);
        chk("verr_no_we", 128'(vrf_we_wb_o), 128'(0));
        chk("verr_no_ret", 128'(perf_instr_ret_wb_o), 128'(0));
        tick(); lsu(1'b0, 1'b0, 32'd0);
        @(negedge clk_i); chk("verr_empty", 128'(ready_wb_o), 128'(1));
        tick(); id_set(5'd0, 32'd0, 1'b0, 1'b0, 5'd5, 128'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); id_idle();
        for (int i = 0; i < 4; i++) begin
            lsu(1'b1, 1'b0, 32'(i + 5));
            @(negedge clk_i);
            tick();
        end
        lsu(1'b0, 1'b0, 32'd0);

        // scalar load with error
        tick(); id_set(5'd9, 32'd0, 1'b1, 1'b1, 5'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); id_idle();
        lsu(1'b1, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk_i);
        chk("lerr_no_we", 128'(rf_we_wb_o), 128'(0));
        chk("lerr_wdata0", 128'(rf_wdata_wb_o), 128'(0));
        tick(); lsu(1'b0, 1'b0, 32'd0);
        @(negedge clk_i); chk("lerr_empty", 128'(ready_wb_o), 128'(1));

        // single-beat vector load on the VLEN=XLEN instance, then reset mid-load on the main one
        tick(); id_set(5'd0, 32'd0, 1'b0, 1'b0, 5'd9, 128'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); id_idle();
        lsu(1'b1, 1'b0, 32'hCAFE_F00D);
        @(negedge clk_i);
        chk("d2_vwe", 128'(d2_vrf_we), 128'(1));
        chk("d2_vdata", 128'(d2_vrf_wdata), 128'(32'hCAFEF00D));
        chk("d2_ret", 128'(d2_ret), 128'(1));
        tick(); lsu(1'b1, 1'b0, 32'h0BAD_F00D);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_ready", 128'(ready_wb_o), 128'(1));
        chk("rst_vwpend", 128'(vrf_wpend_o), 128'(0));
        chk("rst_vwaddr", 128'(vrf_waddr_wb_o), 128'(0));
        chk("rst_vwe", 128'(vrf_we_wb_o), 128'(0));
        chk("rst_d2_ready", 128'(d2_ready), 128'(1));
        lsu(1'b0, 1'b0, 32'd0);
        tick(); tick();
        rst_i = 1'b0;
        tick(); id_set(5'd1, 32'h0000_0001, 1'b1, 1'b0, 5'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); id_idle();
        @(negedge clk_i);
        chk("post_rst_wdata", 128'(rf_wdata_wb_o), 128'(1));
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
